// File: rtl/xip_obi_arbiter.sv
// ---------------------------------------------------------------------------
// xip_obi_arbiter
//
// Two-master to one-slave OBI arbiter in front of the XIP flash controller.
// Master 0 is instruction fetch and master 1 is the data bus. Only one
// transaction is outstanding at the slave at a time, and each response is
// routed back to the master that issued the request. The request path is
// combinational, so the arbiter adds no cycles to the slave latency.
//
// Parameters
//   RR_EN      1: round-robin between the masters; 0: fixed priority, m1 wins
//   WRITE_PASS 1: forward writes to the slave; 0: absorb writes locally and
//              answer them with a zero read-data response one cycle later
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   mN_req_i/we_i/be_i       master N request, write enable, byte enables
//   mN_addr_i/data_i         master N address and write data
//   mN_gnt_o                 master N grant
//   mN_rvalid_o/data_o       master N response valid and read data
//   s_req_o/we_o/be_o        request, write enable and byte enables to XIP
//   s_addr_o/data_o          address and write data to XIP
//   s_gnt_i                  grant from XIP
//   s_rvalid_i/data_i        response valid and read data from XIP
// ---------------------------------------------------------------------------
module xip_obi_arbiter #(
    parameter bit RR_EN      = 1'b1,
    parameter bit WRITE_PASS = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_data_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_data_o,

    output logic        s_req_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        LOCAL_RSP
    } state_t;

    state_t state;
    logic   lock;       // a forwarded request is waiting for s_gnt_i
    logic   owner;      // master that owns the current / pending transaction
    logic   rr_last;    // master served most recently (round-robin pointer)
    logic   local_rsp;  // a locally absorbed write is being answered
    logic   rsp_err;    // sticky: slave response seen with nothing outstanding

    logic        winner;
    logic        win_req;
    logic        win_we;
    logic [3:0]  win_be;
    logic [31:0] win_addr;
    logic [31:0] win_data;
    logic        absorb;
    logic        forward;
    logic        in_idle;
    logic        gnt_win;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    // Winner selection. While locked the held owner is the only candidate;
    // if it dropped its request (protocol violation) nothing is issued and
    // the lock is released below, so arbitration resumes next cycle.
    always_comb begin
        winner  = 1'b0;
        win_req = 1'b0;
        if (lock) begin
            winner  = owner;
            win_req = owner ? m1_req_i : m0_req_i;
        end else if (m0_req_i && m1_req_i) begin
            winner  = RR_EN ? ~rr_last : 1'b1;
            win_req = 1'b1;
        end else if (m1_req_i) begin
            winner  = 1'b1;
            win_req = 1'b1;
        end else if (m0_req_i) begin
            winner  = 1'b0;
            win_req = 1'b1;
        end
    end

    always_comb begin
        win_we   = winner ? m1_we_i   : m0_we_i;
        win_be   = winner ? m1_be_i   : m0_be_i;
        win_addr = winner ? m1_addr_i : m0_addr_i;
        win_data = winner ? m1_data_i : m0_data_i;
    end

    assign absorb  = win_req && win_we && !WRITE_PASS;
    assign forward = win_req && !absorb;
    // Reset gates every output so nothing leaks while rst_ni is low.
    assign in_idle = rst_ni && (state == IDLE);

    // Slave request side: zero unless a request is actually presented.
    always_comb begin
        s_req_o  = in_idle && forward;
        s_we_o   = 1'b0;
        s_be_o   = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (s_req_o) begin
            s_we_o   = win_we;
            s_be_o   = win_be;
            s_addr_o = win_addr;
            s_data_o = win_data;
        end
    end

    // Absorbed writes are granted immediately; forwarded requests follow
    // the slave grant.
    assign gnt_win  = in_idle && (absorb || (forward && s_gnt_i));
    assign m0_gnt_o = gnt_win && !winner;
    assign m1_gnt_o = gnt_win && winner;

    // Response routing: only the owner ever sees rvalid or non-zero data.
    assign rsp_valid = rst_ni && (((state == WAIT_RSP) && s_rvalid_i) || local_rsp);
    assign rsp_data  = (state == WAIT_RSP) ? s_data_i : '0;

    always_comb begin
        m0_rvalid_o = rsp_valid && !owner;
        m1_rvalid_o = rsp_valid && owner;
        m0_data_o   = m0_rvalid_o ? rsp_data : '0;
        m1_data_o   = m1_rvalid_o ? rsp_data : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            lock      <= 1'b0;
            owner     <= 1'b0;
            rr_last   <= 1'b1;
            local_rsp <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_err <= rsp_err | (s_rvalid_i && (state != WAIT_RSP));
            case (state)
                IDLE: begin
                    if (absorb) begin
                        owner     <= winner;
                        lock      <= 1'b0;
                        local_rsp <= 1'b1;
                        state     <= LOCAL_RSP;
                    end else if (forward) begin
                        owner <= winner;
                        if (s_gnt_i) begin
                            lock    <= 1'b0;
                            rr_last <= winner;
                            state   <= WAIT_RSP;
                        end else begin
                            lock <= 1'b1;
                        end
                    end else begin
                        lock <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    if (s_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                LOCAL_RSP: begin
                    rr_last   <= owner;
                    local_rsp <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    local_rsp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/xip_obi_arbiter.md
Name: xip_obi_arbiter

Overview:
- Two-master to one-slave OBI arbiter in front of the XIP flash controller.
- Lets instruction fetch (master 0) and the data bus (master 1) share the single XIP OBI port.
- Keeps at most one transaction outstanding at the slave and routes each response back to the master that issued the request.
- Optionally terminates writes locally, so the read-only flash never sees a write.

Parameters:
- RR_EN, 1: 1 = round-robin between masters; 0 = fixed priority, master 1 (data) wins.
- WRITE_PASS, 0: 1 = forward writes to the slave; 0 = the arbiter absorbs writes locally.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- m0_req_i, m1_req_i  in  1  master request
- m0_we_i, m1_we_i  in  1  write enable
- m0_be_i, m1_be_i  in  4  byte enables
- m0_addr_i, m1_addr_i  in  32  address
- m0_data_i, m1_data_i  in  32  write data
- m0_gnt_o, m1_gnt_o  out  1  grant
- m0_rvalid_o, m1_rvalid_o  out  1  response valid
- m0_data_o, m1_data_o  out  32  read data
- s_req_o  out  1  to XIP: request
- s_we_o  out  1  to XIP: write enable
- s_be_o  out  4  to XIP: byte enables
- s_addr_o  out  32  to XIP: address
- s_data_o  out  32  to XIP: write data
- s_gnt_i  in  1  from XIP: grant
- s_rvalid_i  in  1  from XIP: response valid
- s_data_i  in  32  from XIP: read data

Behaviour:
- One clock domain, clk_i. Reset is asynchronous, active-low (rst_ni).
- During reset:
  - FSM = IDLE, lock = 0, owner = 0, rr_last = 1 (so master 0 wins first in RR mode), local_rsp = 0.
  - All outputs are 0.
- FSM states: IDLE, WAIT_RSP, LOCAL_RSP.
- IDLE, winner selection:
  - If lock = 1, the winner is the held owner.
  - Otherwise, in RR mode the winner is the requesting master that is not rr_last; if only one master requests, that master wins.
  - Otherwise, in fixed mode master 1 wins over master 0.
- IDLE, winner is a write with WRITE_PASS = 0:
  - s_req_o stays 0; winner gnt asserted combinationally in the same cycle.
  - Latch owner. Go to LOCAL_RSP.
- IDLE, all other winners:
  - s_req_o = 1 and s_* are muxed combinationally from the winner.
  - Winner gnt = s_gnt_i; the other master's gnt = 0.
  - If s_gnt_i = 0: set lock = 1 and owner = winner. The selection cannot change until granted, because OBI requires the master to hold its request.
  - If s_gnt_i = 1: latch owner, clear lock, update rr_last = owner, go to WAIT_RSP.
- WAIT_RSP:
  - s_req_o = 0; both gnt outputs = 0.
  - On s_rvalid_i: owner rvalid = 1 and owner data = s_data_i in the same cycle. Go to IDLE.
- LOCAL_RSP (one cycle):
  - Owner rvalid = 1, owner data = 0. rr_last = owner. Go to IDLE.
- Non-owner rvalid and data outputs are always 0.
- Latency and throughput:
  - Minimum read latency = slave latency (zero-cycle arbiter, combinational paths).
  - A new request can be issued in the cycle after the response; no overlap with a response cycle.
  - Peak throughput: one transaction per (slave latency + 1) cycles.
- Boundary and error conditions:
  - s_rvalid_i in IDLE or LOCAL_RSP is ignored (protocol error). A 1-bit sticky flag records it for the simulation assertion.
  - s_gnt_i outside IDLE is ignored.
  - A master that drops req while locked and not yet granted (protocol violation): lock clears and arbitration resumes the next cycle.
  - With both masters requesting continuously in RR mode, grants strictly alternate 0,1,0,1.
  - Reset asserted mid-transaction: everything returns to reset values at once. A response arriving afterwards is dropped as in IDLE.

Test Plan:
- Single read, m0 addr 0x0000_0100, slave gnt immediate, rvalid 3 cycles later with 0xDEAD_BEEF -> m0_gnt_o same cycle as req; m0_rvalid_o=1 with data 0xDEAD_BEEF exactly 3 cycles later; m1 outputs stay 0.
- Both masters request continuously, RR_EN=1, 8 transactions -> grant order 0,1,0,1,0,1,0,1; each response is routed to the issuing master; s_req_o=0 while in WAIT_RSP.
- RR_EN=0, both request -> m1 wins every arbitration; m0 is granted only in cycles where m1_req_i=0.
- Slave withholds gnt 4 cycles while m0 is pending and m1 asserts req at cycle 2 -> s_addr_o stays m0's address for all 5 cycles; m1 is granted only after m0's response.
- WRITE_PASS=0, m1 write to 0x0000_0040 -> s_req_o never asserts; m1_gnt_o at cycle 0; m1_rvalid_o=1 with data 0 at cycle 1. With WRITE_PASS=1 the same stimulus is forwarded with we, be and data intact.
- rst_ni pulsed low during WAIT_RSP, then a stray s_rvalid_i -> all outputs 0 during reset; the stray response is dropped; the next m0 read completes normally.
